// File: rtl/cpu_mem_pkg.sv
// Shared CPU/memory definitions: default bus widths,
// arbiter state encoding and grant encoding.
package cpu_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_IF   = 2'b01,
    GNT_D    = 2'b10
  } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the unified memory port.
// slave = arbiter view, master = CPU/memory environment view.
interface mem_port_arbiter_if
  import cpu_mem_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner select. Fixed D-over-IF priority by default;
// ARB_ROUND_ROBIN_EN alternates on a tie using the last grant.
module arb_pick
  import cpu_mem_pkg::*;
(
  input  logic if_req_i,
  input  logic d_req_i,
  input  gnt_e last_i,
  output gnt_e win_o
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    win_o = GNT_NONE;
    if (d_req_i && if_req_i)
      win_o = (last_i == GNT_D) ? GNT_IF : GNT_D;
    else if (d_req_i)
      win_o = GNT_D;
    else if (if_req_i)
      win_o = GNT_IF;
  end
`else
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    win_o = GNT_NONE;
    if (d_req_i)
      win_o = GNT_D;
    else if (if_req_i)
      win_o = GNT_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes IF and data requests onto one memory port.
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W = cpu_mem_pkg::DATA_W
)(
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus,
  output logic [1:0]         arb_state,
  output logic [1:0]         grant
);

  arb_state_e        state_q, state_d;
  gnt_e              grant_q, grant_d;
  gnt_e              win;
  gnt_e              last_q;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

`ifdef ARB_ROUND_ROBIN_EN
  gnt_e last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && win != GNT_NONE)
      last_d = win;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= GNT_IF;
    else       last_q <= last_d;
  end
`else
  assign last_q = GNT_IF;
`endif

  arb_pick u_pick (
    .if_req_i (bus.if_req),
    .d_req_i  (bus.d_req),
    .last_i   (last_q),
    .win_o    (win)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        grant_d = GNT_NONE;
        if (win != GNT_NONE) begin
          grant_d   = win;
          mem_req_d = 1'b1;
          state_d   = ISSUE;
          if (win == GNT_D) begin
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_ack) begin
          if (!mem_we_q) begin
            if (grant_q == GNT_IF)
              if_rdata_d = bus.mem_rdata;
            else
              d_rdata_d = bus.mem_rdata;
          end
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
      default: begin
        state_d   = IDLE;
        grant_d   = GNT_NONE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // reset has priority over a same-cycle mem_ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ack    = (state_q == RESP) && (grant_q == GNT_IF);
  assign bus.d_ack     = (state_q == RESP) && (grant_q == GNT_D);
  assign arb_state     = state_q;
  assign grant         = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Also exercises round-robin order when ARB_ROUND_ROBIN_EN is defined.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] arb_state;
  logic [1:0] grant;

  int n_chk;
  int n_err;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .arb_state (arb_state),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(arb_state), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_mreq", 32'(bus.mem_req), 32'd0);
    chk("rst_ifack", 32'(bus.if_ack), 32'd0);
    chk("rst_dack", 32'(bus.d_ack), 32'd0);
    chk("rst_ifrd", bus.if_rdata, 32'd0);
    chk("rst_drd", bus.d_rdata, 32'd0);
    reset = 1'b0;
    tick();

    // data read with 4 wait states
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0020;
    bus.mem_rdata = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ws_mreq", 32'(bus.mem_req), 32'd1);
      chk("ws_maddr", 32'(bus.mem_addr), 32'h20);
      chk("ws_dack", 32'(bus.d_ack), 32'd0);
      if (i == 4) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
      end
    end
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h2222_2222;
    chk("ws_dack1", 32'(bus.d_ack), 32'd1);
    chk("ws_drd", bus.d_rdata, 32'h0BAD_F00D);
    bus.d_req = 1'b0;
    tick();
    chk("ws_dack2", 32'(bus.d_ack), 32'd0);
    chk("ws_idle", 32'(arb_state), 32'd0);

    // zero-wait fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0004;
    tick();
    chk("f_mreq", 32'(bus.mem_req), 32'd1);
    chk("f_maddr", 32'(bus.mem_addr), 32'h4);
    chk("f_grant", 32'(grant), 32'd1);
    chk("f_state", 32'(arb_state), 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack = 1'b0;
    chk("f_ifack", 32'(bus.if_ack), 32'd1);
    chk("f_ifrd", bus.if_rdata, 32'hDEAD_BEEF);
    chk("f_resp", 32'(arb_state), 32'd2);
    chk("f_mreq0", 32'(bus.mem_req), 32'd0);
    bus.if_req = 1'b0;
    tick();
    chk("f_idle", 32'(arb_state), 32'd0);
    chk("f_gnone", 32'(grant), 32'd0);

    // simultaneous IF read and D write
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0008;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0010;
    bus.d_wdata = 32'h1234_5678;
    tick();
    chk("s_grant", 32'(grant), 32'd2);
    chk("s_we", 32'(bus.mem_we), 32'd1);
    chk("s_maddr", 32'(bus.mem_addr), 32'h10);
    chk("s_wdata", bus.mem_wdata, 32'h1234_5678);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h9999_9999;
    tick();
    bus.mem_ack = 1'b0;
    chk("s_dack", 32'(bus.d_ack), 32'd1);
    chk("s_ifack0", 32'(bus.if_ack), 32'd0);
    chk("s_drd", bus.d_rdata, 32'h0BAD_F00D);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    chk("s_idle", 32'(arb_state), 32'd0);
    tick();
    chk("s_grant2", 32'(grant), 32'd1);
    chk("s_maddr2", 32'(bus.mem_addr), 32'h8);
    chk("s_we2", 32'(bus.mem_we), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_ack = 1'b0;
    chk("s_ifack", 32'(bus.if_ack), 32'd1);
    chk("s_ifrd", bus.if_rdata, 32'hCAFE_F00D);
    chk("s_drd2", bus.d_rdata, 32'h0BAD_F00D);
    bus.if_req = 1'b0;
    tick();

    // reset during ISSUE, late mem_ack ignored
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0040;
    tick();
    chk("r_issue", 32'(arb_state), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.if_req = 1'b0;
    chk("r_mreq", 32'(bus.mem_req), 32'd0);
    chk("r_state", 32'(arb_state), 32'd0);
    chk("r_ifack", 32'(bus.if_ack), 32'd0);
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_5555;
    tick();
    bus.mem_ack = 1'b0;
    chk("r_late_st", 32'(arb_state), 32'd0);
    chk("r_late_ack", 32'(bus.if_ack), 32'd0);
    chk("r_late_rd", bus.if_rdata, 32'd0);
    tick();
    chk("r_late_ack2", 32'(bus.if_ack | bus.d_ack), 32'd0);

    // reset and mem_ack in the same cycle
    bus.d_req  = 1'b1;
    bus.d_addr = 16'h0030;
    tick();
    reset         = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    tick();
    reset       = 1'b0;
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    chk("ra_drd", bus.d_rdata, 32'd0);
    chk("ra_state", 32'(arb_state), 32'd0);
    tick();
    chk("ra_dack", 32'(bus.d_ack), 32'd0);

    // if_req held through its ack: no re-grant in RESP
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0100;
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hA5A5_A5A5;
    tick();
    bus.mem_ack = 1'b0;
    chk("h_ifack", 32'(bus.if_ack), 32'd1);
    bus.if_addr = 16'h0104;
    tick();
    chk("h_idle", 32'(arb_state), 32'd0);
    chk("h_mreq0", 32'(bus.mem_req), 32'd0);
    chk("h_ifack0", 32'(bus.if_ack), 32'd0);
    tick();
    chk("h_issue", 32'(arb_state), 32'd1);
    chk("h_maddr", 32'(bus.mem_addr), 32'h104);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0104;
    tick();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    chk("h_ifrd", bus.if_rdata, 32'h0000_0104);
    tick();

`ifdef ARB_ROUND_ROBIN_EN
    // both held continuously: D, IF, D, IF
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0200;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h0300;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_grant", 32'(grant), (k % 2 == 0) ? 32'd2 : 32'd1);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      tick();
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
